// File: rtl/tx_engine_arbiter.sv
// Round-robin arbiter granting one of C_NUM_CHNL request channels to the TX engine.
// Define TX_ENGINE_ARB_QUANTUM_EN to force rotation after C_QUANTUM packets per grant.
module tx_engine_arbiter #(
    parameter int C_NUM_CHNL = 12,
    parameter int C_CHNL_W   = (C_NUM_CHNL > 1) ? $clog2(C_NUM_CHNL) : 1,
    parameter int C_QUANTUM  = 8
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic [C_NUM_CHNL-1:0] REQ_ALL,
    input  logic                  REQ_DONE,
    output logic                  REQ,
    output logic [C_CHNL_W-1:0]   CHNL
);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        SWITCH
    } arbState_t;

    arbState_t             state;
    arbState_t             stateNext;
    logic [C_CHNL_W-1:0]   rPtr;
    logic [C_CHNL_W-1:0]   ptrNext;
    logic [C_CHNL_W-1:0]   chnlNext;
    logic                  reqNext;
    logic [C_CHNL_W-1:0]   winIdx;
    logic [C_CHNL_W-1:0]   hiIdx;
    logic [C_CHNL_W-1:0]   loIdx;
    logic                  hiFound;
    logic                  winFound;
    logic [C_NUM_CHNL-1:0] chnlMask;
    logic                  qexp;
    logic                  grantRelease;

    // Rotating priority as two scans: lowest requester above rPtr wins, else the lowest
    // requester overall, which leaves rPtr itself checked last.
    // NOTE: every variable driven here gets a default first so no path can infer a latch.
    always_comb begin
        hiFound  = 1'b0;
        winFound = 1'b0;
        hiIdx    = '0;
        loIdx    = '0;
        for (int i = C_NUM_CHNL - 1; i >= 0; i--) begin
            if (REQ_ALL[i]) begin
                winFound = 1'b1;
                loIdx    = C_CHNL_W'(i);
                if (C_CHNL_W'(i) > rPtr) begin
                    hiFound = 1'b1;
                    hiIdx   = C_CHNL_W'(i);
                end
            end
        end
        winIdx = hiFound ? hiIdx : loIdx;
    end

    assign chnlMask     = C_NUM_CHNL'(1) << CHNL;
    assign grantRelease = (state == GRANT) & (~(|(REQ_ALL & chnlMask)) | qexp);

`ifdef TX_ENGINE_ARB_QUANTUM_EN
    localparam logic [7:0] C_QLAST = 8'(C_QUANTUM - 1);

    logic [7:0] rCount;
    logic [7:0] countNext;
    logic       countLast;
    logic       otherPending;

    assign countLast    = (rCount == C_QLAST);
    assign otherPending = |(REQ_ALL & ~chnlMask);
    assign qexp         = REQ_DONE & countLast & otherPending;

    // Saturates at the last slot when nobody else waits, so expiry fires on the next packet.
    always_comb begin
        countNext = rCount;
        if (grantRelease) begin
            countNext = '0;
        end else if ((state == GRANT) && REQ_DONE && !countLast) begin
            countNext = rCount + 8'd1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rCount <= '0;
        end else begin
            rCount <= countNext;
        end
    end
`else
    logic unusedQuantum;

    assign unusedQuantum = REQ_DONE | (C_QUANTUM == 0);
    assign qexp          = 1'b0;
`endif

    // IDLE and SWITCH both search with the live REQ_ALL; SWITCH exists to give the gap cycle.
    always_comb begin
        stateNext = state;
        reqNext   = REQ;
        chnlNext  = CHNL;
        ptrNext   = rPtr;
        case (state)
            IDLE, SWITCH: begin
                if (winFound) begin
                    chnlNext  = winIdx;
                    reqNext   = 1'b1;
                    stateNext = GRANT;
                end else begin
                    reqNext   = 1'b0;
                    stateNext = IDLE;
                end
            end
            GRANT: begin
                if (grantRelease) begin
                    reqNext   = 1'b0;
                    ptrNext   = CHNL;
                    stateNext = SWITCH;
                end
            end
            default: begin
                reqNext   = 1'b0;
                stateNext = IDLE;
            end
        endcase
    end

    // NOTE: reset is asynchronous so REQ drops the moment RST_N falls; all state is small
    // control flops, so every one of them is reset.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
            REQ   <= 1'b0;
            CHNL  <= '0;
            rPtr  <= C_CHNL_W'(C_NUM_CHNL - 1);
        end else begin
            state <= stateNext;
            REQ   <= reqNext;
            CHNL  <= chnlNext;
            rPtr  <= ptrNext;
        end
    end

endmodule
